// File: rtl/ysyx_ifu.sv
// ysyx_ifu -- single-outstanding instruction fetch unit.
//
// The unit fetches one word at a time. It issues a request for the current PC,
// waits for the response, and then holds the word for the decoder until the
// decoder takes it. A redirect (a taken jump or branch) replaces the PC at any
// point. If a redirect arrives while a request is in flight, the unit marks
// that response as stale and discards it when it returns.
//
// Ports
//   clk, rst_n                  clock; synchronous active-low reset
//   imem_req_valid/ready        fetch request handshake
//   imem_addr                   fetch address (the current PC)
//   imem_rsp_valid, _data       response for the oldest accepted request
//   inst_valid/ready            decoder handshake
//   inst, pc                    buffered instruction and the address it came from
//   redirect_valid, redirect_pc control-flow change; target is word-aligned
module ysyx_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic        r_drop, w_drop_nxt;
  logic [31:0] w_tgt;

  // Instructions are word-aligned, so the low two bits of the target are cleared.
  assign w_tgt = redirect_pc & ~32'h3;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst;
    w_drop_nxt  = r_drop;
    case (r_state)
      S_REQ: begin
        if (imem_req_ready) w_state_nxt = S_WAIT;
        if (redirect_valid) begin
          w_pc_nxt = w_tgt;
          // The request just accepted is for the old PC, so its data is stale.
          if (imem_req_ready) w_drop_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (r_drop || redirect_valid) begin
            w_state_nxt = S_REQ;
            w_drop_nxt  = 1'b0;
          end else begin
            w_inst_nxt  = imem_rsp_data;
            w_state_nxt = S_OUT;
          end
          if (redirect_valid) w_pc_nxt = w_tgt;
        end else if (redirect_valid) begin
          w_pc_nxt   = w_tgt;
          w_drop_nxt = 1'b1;
        end
      end
      S_OUT: begin
        // A redirect wins over the sequential increment, even when the
        // handshake completes in the same cycle.
        if (redirect_valid) begin
          w_pc_nxt    = w_tgt;
          w_state_nxt = S_REQ;
        end else if (inst_ready) begin
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_inst  <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_inst  <= w_inst_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  // The request is gated by rst_n so that no request is shown while reset is held.
  assign imem_req_valid = rst_n && (r_state == S_REQ);
  assign imem_addr      = r_pc;
  assign inst_valid     = (r_state == S_OUT);
  assign inst           = r_inst;
  assign pc             = r_pc;

endmodule

// File: tb/tb_ysyx_ifu.sv
// Testbench for ysyx_ifu. It drives randomized memory, decoder and redirect
// traffic. A reference model of the architectural fetch stream pushes the
// expected (pc, inst) pairs into a scoreboard. A monitor process pops the
// scoreboard on each decoder handshake, and it also checks reset values,
// output stability and single-outstanding behaviour.
module tb_ysyx_ifu;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  ysyx_ifu #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .pc(pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int checks = 0, failures = 0;

  // Stimulus knobs (percent probabilities, response delay range).
  int p_ready = 100, p_iready = 100, p_redir = 0, p_spur = 0, dmin = 1, dmax = 1;
  bit want_rst = 1'b0, tput_chk = 1'b0;
  bit trig_wait_redir = 1'b0, trig_out_redir = 1'b0, trig_wait_rst = 1'b0;
  logic [31:0] trig_tgt = '0;

  // Reference model: the next architectural fetch PC, plus a one-deep memory.
  logic [31:0] exp_pc = RST_PC, exp_now = RST_PC, paddr = '0;
  bit          pending = 1'b0, busy_now = 1'b0;
  int          cnt = 0, n_cons = 0;
  logic [63:0] sb_q[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", nm);
  endtask

  // One cycle of stimulus. The inputs are set shortly after the falling edge
  // and the model is advanced to the state it will have after the next rising edge.
  task automatic drive();
    bit rn, acc, cons, rd;
    logic [31:0] tgt;
    @(negedge clk);
    exp_now  = exp_pc;
    busy_now = pending;
    rn = want_rst;
    if (trig_wait_rst && busy_now) begin rn = 1'b0; trig_wait_rst = 1'b0; end
    rst_n = rn;
    #1;
    if (!rn) pending = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pending) begin
      cnt--;
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memfn(paddr);
        pending        = 1'b0;
      end
    end else if ($urandom_range(99) < p_spur) begin
      imem_rsp_valid = 1'b1;
    end
    imem_req_ready = ($urandom_range(99) < p_ready);
    acc = rn && imem_req_valid && imem_req_ready;
    if (acc) begin
      pending = 1'b1;
      paddr   = imem_addr;
      cnt     = $urandom_range(dmax, dmin);
    end
    inst_ready = ($urandom_range(99) < p_iready);
    rd  = rn && ($urandom_range(99) < p_redir);
    tgt = 32'h8000_0000 | ($urandom & 32'hFFF);
    if (rn && trig_wait_redir && busy_now) begin
      rd = 1'b1; tgt = trig_tgt; trig_wait_redir = 1'b0;
    end
    if (rn && trig_out_redir && inst_valid) begin
      rd = 1'b1; inst_ready = 1'b1; tgt = trig_tgt; trig_out_redir = 1'b0;
    end
    redirect_valid = rd;
    redirect_pc    = rd ? tgt : $urandom;
    cons = rn && inst_valid && inst_ready;
    if (!rn) exp_pc = RST_PC;
    else begin
      if (cons) sb_q.push_back({exp_pc, memfn(exp_pc)});
      if (rd) exp_pc = {tgt[31:2], 2'b00};
      else if (cons) exp_pc = exp_pc + 32'd4;
    end
  endtask

  // Monitor
  int          cyc = 0, last_cons = -1;
  bit          prev_rst = 1'b0, prev_iv = 1'b0, prev_ir = 1'b0, prev_rd = 1'b0;
  bit          prev_rv = 1'b0, prev_rr = 1'b0;
  logic [31:0] prev_inst = '0, prev_pc = '0, prev_addr = '0;

  always begin
    logic [63:0] e;
    @(negedge clk);
    #2;
    cyc++;
    if (!prev_rst) begin
      chk("rst_req_valid", {31'b0, imem_req_valid}, {31'b0, rst_n});
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_pc", pc, RST_PC);
      last_cons = -1;
    end else begin
      if (imem_req_valid) chk("req_addr", imem_addr, exp_now);
      if (busy_now) chk("one_outstanding", {31'b0, imem_req_valid}, 32'd0);
      if (prev_iv && !prev_ir && !prev_rd) begin
        chk("hold_valid", {31'b0, inst_valid}, 32'd1);
        chk("hold_inst", inst, prev_inst);
        chk("hold_pc", pc, prev_pc);
      end
      if (prev_rv && !prev_rr && !prev_rd && rst_n) begin
        chk("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("req_hold_addr", imem_addr, prev_addr);
      end
      if (inst_valid && inst_ready && rst_n) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty actual=pc %h expected=no output", pc);
        end else begin
          e = sb_q.pop_front();
          chk("out_pc", pc, e[63:32]);
          chk("out_inst", inst, e[31:0]);
        end
        if (tput_chk && last_cons >= 0) chk("tput_gap", 32'(cyc - last_cons), 32'd3);
        last_cons = cyc;
        n_cons++;
      end
    end
    prev_rst  = rst_n;
    prev_iv   = inst_valid;
    prev_ir   = inst_ready;
    prev_rd   = redirect_valid;
    prev_rv   = imem_req_valid;
    prev_rr   = imem_req_ready;
    prev_inst = inst;
    prev_pc   = pc;
    prev_addr = imem_addr;
  end

  initial begin
    bit seen;
    // Reset, then memory stalls the first request for four cycles.
    want_rst = 1'b0;
    repeat (3) drive();
    want_rst = 1'b1;
    p_ready  = 0;
    repeat (4) drive();
    // Zero-wait memory: one instruction every three cycles.
    p_ready  = 100;
    tput_chk = 1'b1;
    repeat (13) drive();
    tput_chk = 1'b0;

    // Decoder stall for five cycles while an instruction is held.
    p_iready = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      drive();
      seen = inst_valid;
    end
    if (!seen) timeout("wait_inst_valid");
    repeat (5) drive();
    p_iready = 100;
    repeat (6) drive();

    // Redirect while waiting for a slow response: the response is dropped.
    dmin = 3; dmax = 3;
    trig_tgt = 32'h8000_0103;
    trig_wait_redir = 1'b1;
    for (int i = 0; i < 30 && trig_wait_redir; i++) drive();
    if (trig_wait_redir) begin trig_wait_redir = 1'b0; timeout("wait_redir_in_wait"); end
    repeat (15) drive();
    dmin = 1; dmax = 3;

    // Redirect coincident with the decoder handshake.
    trig_tgt = 32'h8000_0040;
    trig_out_redir = 1'b1;
    for (int i = 0; i < 30 && trig_out_redir; i++) drive();
    if (trig_out_redir) begin trig_out_redir = 1'b0; timeout("wait_redir_in_out"); end
    repeat (10) drive();

    // Reset while waiting, with stray responses around it.
    p_spur = 100;
    trig_wait_rst = 1'b1;
    for (int i = 0; i < 30 && trig_wait_rst; i++) drive();
    if (trig_wait_rst) begin trig_wait_rst = 1'b0; timeout("wait_rst_in_wait"); end
    repeat (2) drive();
    p_spur = 0;
    repeat (10) drive();

    // Randomized traffic.
    for (int b = 0; b < 12; b++) begin
      p_ready  = $urandom_range(100, 20);
      p_iready = $urandom_range(100, 20);
      p_redir  = $urandom_range(15, 0);
      p_spur   = $urandom_range(30, 0);
      dmin     = 1;
      dmax     = $urandom_range(4, 1);
      if (b % 4 == 3) begin
        want_rst = 1'b0;
        drive();
        want_rst = 1'b1;
      end
      repeat (250) drive();
    end

    if (n_cons < 100) begin
      checks++;
      failures++;
      $display("FAIL liveness actual=%0d expected>=100", n_cons);
    end else checks++;
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_ifu.md
YSYX_IFU -- requirements
Module: ysyx_IFU

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL be the PC loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 imem_req_valid  output  1  SHALL flag a fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  SHALL mean memory accepts the request this cycle.
REQ-006 imem_addr  output  32  SHALL be the fetch address, equal to the current PC.
REQ-007 imem_rsp_valid  input  1  SHALL mean imem_rsp_data holds the word for the oldest accepted request.
REQ-008 imem_rsp_data  input  32  SHALL be the returned instruction word.
REQ-009 inst_valid  output  1  SHALL mean inst/pc hold a fetched instruction for the decoder.
REQ-010 inst_ready  input  1  SHALL mean the decoder consumes inst/pc this cycle.
REQ-011 inst  output  32  SHALL be the buffered instruction word.
REQ-012 pc  output  32  SHALL be the address inst was fetched from.
REQ-013 redirect_valid  input  1  SHALL request a control-flow change (jump/branch taken).
REQ-014 redirect_pc  input  32  SHALL be the redirect target.

Function
REQ-015 The FSM SHALL have exactly three states: S_REQ, S_WAIT, S_OUT.
REQ-016 In S_REQ: imem_req_valid=1, imem_addr=pc_q; on imem_req_ready=1 go to S_WAIT; otherwise hold, with imem_addr stable.
REQ-017 In S_WAIT: imem_req_valid=0; on imem_rsp_valid=1 capture imem_rsp_data into inst_q and go to S_OUT, unless the drop flag is set.
REQ-018 In S_OUT: inst_valid=1, inst=inst_q, pc=pc_q; on inst_ready=1 set pc_q to pc_q+4 (modulo 2^32) and go to S_REQ.
REQ-019 inst_valid SHALL be 0 in S_REQ and S_WAIT; inst and pc SHALL stay stable while inst_valid=1 and inst_ready=0.
REQ-020 At most one request SHALL be outstanding; no new request until the prior response is received or dropped.
REQ-021 imem_rsp_valid outside S_WAIT SHALL be ignored.
REQ-022 Redirect target SHALL be loaded as {redirect_pc[31:2],2'b00}.
REQ-023 Redirect in S_REQ with imem_req_ready=0: pc_q gets the target and the FSM stays in S_REQ; the request is reissued with the new address next cycle.
REQ-024 Redirect in S_REQ with imem_req_ready=1: the request is accepted, pc_q gets the target, drop=1, and the FSM goes to S_WAIT.
REQ-025 Redirect in S_WAIT (no response this cycle): pc_q gets the target and drop=1.
REQ-026 In S_WAIT with drop=1, a response SHALL be discarded, drop cleared, and the FSM SHALL go to S_REQ; inst_valid stays 0.
REQ-027 Redirect in S_WAIT coincident with imem_rsp_valid: the response is discarded, pc_q gets the target, and the FSM goes to S_REQ.
REQ-028 Redirect in S_OUT: pc_q gets the target and the FSM goes to S_REQ; if inst_ready=1 the same cycle, the handshake completes and the redirect overrides pc_q+4.
REQ-029 Redirect SHALL always take priority over sequential PC increment.
REQ-030 Minimum throughput with zero-wait memory (ready=1, response the cycle after acceptance) and inst_ready=1 SHALL be one instruction per 3 cycles.

Reset
REQ-031 While rst_n=0 at a clock edge: state=S_REQ, pc_q=RESET_PC, inst_q=0, drop=0.
REQ-032 Output values under reset SHALL be: imem_req_valid=1 from the first cycle after reset release (0 while rst_n=0), imem_addr=RESET_PC, inst_valid=0, inst=0, pc=RESET_PC.
REQ-033 Reset mid-transaction SHALL abandon any outstanding request; the memory model is reset together with the block.

Verification
REQ-034 Reset release, memory always ready, one-cycle response, inst_ready=1 -> fetches at 0x80000000, 0x80000004, 0x80000008, with inst_valid pulsing every 3rd cycle.
REQ-035 inst_ready held 0 for 5 cycles in S_OUT -> inst and pc stay constant; no imem_req_valid; after release the next request goes to pc+4.
REQ-036 imem_req_ready=0 for 4 cycles -> imem_req_valid=1 and imem_addr=0x80000000 held steady throughout.
REQ-037 Redirect to 0x80000103 while in S_WAIT -> the pending response is discarded (no inst_valid); the next request goes to 0x80000100.
REQ-038 Redirect coincident with inst_ready=1 in S_OUT (pc=0x80000010, target 0x80000040) -> the next request goes to 0x80000040, not 0x80000014.
REQ-039 rst_n=0 asserted in S_WAIT -> the next cycle shows state S_REQ, pc=RESET_PC, inst_valid=0, and the late response is ignored.
